// File: rtl/bin2bcd_amisha_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_amisha_pkg
//   Shared constants and types for the binary-to-BCD converter.
//   - state_e    : FSMD control states (idle/op/done)
//   - BIN_W      : operand width in bits
//   - DIGITS     : number of packed BCD digits produced
//   - OP_CYCLES  : shift/adjust iterations per conversion
//   - CNT_W      : width of the iteration counter
//   - BCD_W      : width of the packed BCD result
// ---------------------------------------------------------------------------
package bin2bcd_amisha_pkg;

  localparam int unsigned BIN_W     = 20;
  localparam int unsigned DIGITS    = 7;
  localparam int unsigned OP_CYCLES = 20;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned BCD_W     = 4 * DIGITS;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOp   = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/bcd_adj_amisha.sv
// ---------------------------------------------------------------------------
// bcd_adj_amisha
//   Double-dabble digit correction: a BCD digit greater than 4 gets 3 added
//   (modulo 16) so that the following left shift carries correctly into the
//   next decimal digit.
//   Ports:
//     digit      in   4  working BCD digit before the shift
//     digit_adj  out  4  corrected digit
// ---------------------------------------------------------------------------
module bcd_adj_amisha (
  input  logic [3:0] digit,
  output logic [3:0] digit_adj
);

  always_comb begin
    digit_adj = digit;
    if (digit > 4'd4) begin
      digit_adj = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_amisha.sv
// ---------------------------------------------------------------------------
// bin2bcd_amisha
//   Sequential 20-bit binary to 7-digit packed BCD converter (double dabble).
//   A start in idle captures the operand; 20 adjust-and-shift cycles follow;
//   the result is loaded into bcd_amisha on the final shift edge and a
//   one-cycle done_tick_amisha follows. The previous result stays visible
//   for the whole of the next conversion.
//   Ports:
//     clk_amisha        in   1   rising-edge clock
//     reset_amisha      in   1   asynchronous active-high reset
//     start_amisha      in   1   conversion request, honoured only in idle
//     bin_amisha        in   20  unsigned operand, captured on accept
//     ready_amisha      out  1   high while idle
//     done_tick_amisha  out  1   one-cycle pulse after the result loads
//     bcd_amisha        out  28  packed BCD, [27:24] = 10^6 .. [3:0] = 10^0
// ---------------------------------------------------------------------------
module bin2bcd_amisha
  import bin2bcd_amisha_pkg::*;
(
  input  logic              clk_amisha,
  input  logic              reset_amisha,
  input  logic              start_amisha,
  input  logic [BIN_W-1:0]  bin_amisha,
  output logic              ready_amisha,
  output logic              done_tick_amisha,
  output logic [BCD_W-1:0]  bcd_amisha
);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   work_q,  work_d;
  logic [CNT_W-1:0]   n_q,     n_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;

  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_shifted;
  logic [BIN_W-1:0]   shift_shifted;
  logic [CNT_W-1:0]   n_dec;
  logic               unused_top_bit;

  // Per-digit correction applied to the current working digits.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_adj_amisha u_adj (
      .digit     (work_q[4*i +: 4]),
      .digit_adj (work_adj[4*i +: 4])
    );
  end

  // Digit chain and shift register move left together; the operand MSB
  // enters digit 0. The top bit of digit 6 falls off (never set for a
  // 20-bit operand, whose maximum fits in 7 digits).
  assign work_shifted   = {work_adj[BCD_W-2:0], shift_q[BIN_W-1]};
  assign shift_shifted  = {shift_q[BIN_W-2:0], 1'b0};
  assign n_dec          = n_q - CNT_W'(1);
  assign unused_top_bit = work_adj[BCD_W-1];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    n_d     = n_q;
    bcd_d   = bcd_q;
    case (state_q)
      StIdle: begin
        if (start_amisha) begin
          shift_d = bin_amisha;
          work_d  = '0;
          n_d     = CNT_W'(OP_CYCLES);
          state_d = StOp;
        end
      end
      StOp: begin
        work_d  = work_shifted;
        shift_d = shift_shifted;
        n_d     = n_dec;
        if (n_dec == '0) begin
          bcd_d   = work_shifted;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q <= StIdle;
      shift_q <= '0;
      work_q  <= '0;
      n_q     <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      n_q     <= n_d;
      bcd_q   <= bcd_d;
    end
  end

  // Outputs decode the state register only; no input reaches them directly.
  assign ready_amisha     = (state_q == StIdle);
  assign done_tick_amisha = (state_q == StDone);
  assign bcd_amisha       = bcd_q;

endmodule
